ysyx_24090018_fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer: owns the fetch PC, issues one instruction-memory request at a time

---
 rtl/ysyx_24090018_fetch_ctrl.sv | 117 +++++++++++
 tb/tb_ysyx_24090018_fetch_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090018_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one IMEM request in flight,
// buffers the returned word toward decode and applies redirects, dropping stale responses.
module ysyx_24090018_fetch_ctrl #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  imem_req_valid_o,
    input  logic                  imem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] imem_req_addr_o,
    input  logic                  imem_resp_valid_i,
    input  logic [INST_WIDTH-1:0] imem_resp_data_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    discard_q, discard_d;
    logic [INST_WIDTH-1:0]   inst_q, inst_d;
    logic [ADDR_WIDTH-1:0]   inst_pc_q, inst_pc_d;

    assign imem_req_valid_o = (state_q == S_REQ);
    assign imem_req_addr_o  = pc_q;
    assign pc_o             = pc_q;
    assign inst_valid_o     = (state_q == S_HOLD);
    assign inst_o           = inst_q;
    assign inst_pc_o        = inst_pc_q;

    always_comb begin
        // NOTE: every next-state value gets its hold default first so no path infers a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;

        unique case (state_q)
            S_IDLE: state_d = S_REQ;

            S_REQ: begin
                if (redirect_valid_i) pc_d = redirect_pc_i;
                if (imem_req_ready_i) begin
                    state_d = S_WAIT;
                    // The accepted request targets the old PC, so its response is stale.
                    if (redirect_valid_i) discard_d = 1'b1;
                end
            end

            S_WAIT: begin
                if (redirect_valid_i) pc_d = redirect_pc_i;
                if (imem_resp_valid_i) begin
                    if (discard_q || redirect_valid_i) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        inst_d    = imem_resp_data_i;
                        inst_pc_d = pc_q;
                        state_d   = S_HOLD;
                    end
                end else if (redirect_valid_i) begin
                    discard_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (redirect_valid_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = S_REQ;
                end else if (inst_ready_i) begin
                    pc_d    = pc_q + ADDR_WIDTH'(4);
                    state_d = S_REQ;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // A response to a request issued before reset may still drain while in IDLE.
    resp_only_when_waiting: assert property (
        @(posedge clk) disable iff (rst)
        imem_resp_valid_i |-> (state_q == S_WAIT || state_q == S_IDLE)
    );

endmodule

// File: tb/tb_ysyx_24090018_fetch_ctrl.sv
// Self-checking bench for the fetch sequencer: drives IMEM/IDU handshakes and
// checks delivered instructions against a scoreboard of words expected to reach decode.
module tb_ysyx_24090018_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc;

    int          n_checks = 0;
    int          n_fail = 0;
    sb_entry_t   sb[$];

    ysyx_24090018_fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .redirect_valid_i  (redirect_valid),
        .redirect_pc_i     (redirect_pc),
        .imem_req_valid_o  (req_valid),
        .imem_req_ready_i  (req_ready),
        .imem_req_addr_o   (req_addr),
        .imem_resp_valid_i (resp_valid),
        .imem_resp_data_i  (resp_data),
        .inst_valid_o      (inst_valid),
        .inst_ready_i      (inst_ready),
        .inst_o            (inst),
        .inst_pc_o         (inst_pc),
        .pc_o              (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, check its address, accept it (optionally with a same-cycle redirect).
    task automatic issue_req(input logic [31:0] exp_addr, input logic redir, input logic [31:0] tgt);
        int n = 0;
        while (req_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        n_checks++;
        if (req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL req_timeout: req_valid=%b required 1", req_valid);
        end
        n_checks++;
        if (req_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL req_addr: got %h required %h", req_addr, exp_addr);
        end
        req_ready      = 1'b1;
        redirect_valid = redir;
        redirect_pc    = tgt;
        tick();
        req_ready      = 1'b0;
        redirect_valid = 1'b0;
        n_checks++;
        if (req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL req_after_accept: req_valid=%b required 0", req_valid);
        end
    endtask

    // Return a response; words expected to reach decode are pushed to the scoreboard.
    task automatic respond(input logic [31:0] data, input logic deliver, input logic [31:0] fetch_pc,
                           input logic redir, input logic [31:0] tgt);
        sb_entry_t e;
        resp_valid     = 1'b1;
        resp_data      = data;
        redirect_valid = redir;
        redirect_pc    = tgt;
        if (deliver) begin
            e.pc   = fetch_pc;
            e.data = data;
            sb.push_back(e);
        end
        tick();
        resp_valid     = 1'b0;
        redirect_valid = 1'b0;
        n_checks++;
        if (inst_valid !== deliver) begin
            n_fail++;
            $display("FAIL resp_to_valid: inst_valid=%b required %b", inst_valid, deliver);
        end
    endtask

    // Consume the buffered word (optionally with a same-cycle redirect) and compare to scoreboard.
    task automatic consume(input logic redir, input logic [31:0] tgt);
        sb_entry_t e;
        int n = 0;
        while (inst_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        n_checks++;
        if (inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL inst_timeout: inst_valid=%b required 1", inst_valid);
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: unexpected inst %h pc %h", inst, inst_pc);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (inst !== e.data || inst_pc !== e.pc) begin
                n_fail++;
                $display("FAIL inst_data: got %h@%h required %h@%h", inst, inst_pc, e.data, e.pc);
            end
        end
        inst_ready     = 1'b1;
        redirect_valid = redir;
        redirect_pc    = tgt;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        n_checks++;
        if (inst_valid !== 1'b0 || req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL after_consume: inst_valid=%b req_valid=%b required 0/1", inst_valid, req_valid);
        end
        if (redir) begin
            n_checks++;
            if (req_addr !== tgt) begin
                n_fail++;
                $display("FAIL hold_redirect_addr: got %h required %h", req_addr, tgt);
            end
        end
    endtask

    task automatic fetch_plain(input logic [31:0] a);
        issue_req(a, 1'b0, '0);
        respond(word_at(a), 1'b1, a, 1'b0, '0);
        consume(1'b0, '0);
    endtask

    task automatic redirect_one_cycle(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids: req=%b inst=%b required 0/0", req_valid, inst_valid);
        end
        n_checks++;
        if (pc !== RESET_PC || inst_pc !== RESET_PC || inst !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: pc=%h inst_pc=%h inst=%h", pc, inst_pc, inst);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_req: valid=%b addr=%h required 1/%h", req_valid, req_addr, RESET_PC);
        end
    endtask

    task automatic test_straight_line();
        for (int i = 0; i < 3; i++) fetch_plain(RESET_PC + 32'(4 * i));
    endtask

    task automatic test_hold_stall();
        logic [31:0] a;
        a = RESET_PC + 32'hC;
        issue_req(a, 1'b0, '0);
        respond(word_at(a), 1'b1, a, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (inst_valid !== 1'b1 || req_valid !== 1'b0 || inst !== word_at(a) || inst_pc !== a) begin
                n_fail++;
                $display("FAIL hold_stable: v=%b req=%b inst=%h pc=%h", inst_valid, req_valid, inst, inst_pc);
            end
        end
        consume(1'b0, '0);
    endtask

    task automatic test_redirect_req();
        // Unaccepted request may retarget; accepted-with-redirect response must be dropped.
        redirect_one_cycle(RESET_PC + 32'h40);
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== RESET_PC + 32'h40) begin
            n_fail++;
            $display("FAIL req_redirect: valid=%b addr=%h required 1/%h", req_valid, req_addr, RESET_PC + 32'h40);
        end
        issue_req(RESET_PC + 32'h40, 1'b1, RESET_PC + 32'h80);
        n_checks++;
        if (pc !== RESET_PC + 32'h80) begin
            n_fail++;
            $display("FAIL accept_redirect_pc: got %h required %h", pc, RESET_PC + 32'h80);
        end
        respond(word_at(RESET_PC + 32'h40), 1'b0, '0, 1'b0, '0);
        fetch_plain(RESET_PC + 32'h80);
    endtask

    task automatic test_redirect_wait();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        fetch_plain(RESET_PC);
        issue_req(RESET_PC + 32'h4, 1'b0, '0);
        redirect_one_cycle(RESET_PC + 32'h100);
        n_checks++;
        if (req_valid !== 1'b0 || inst_valid !== 1'b0 || pc !== RESET_PC + 32'h100) begin
            n_fail++;
            $display("FAIL wait_redirect: req=%b inst=%b pc=%h", req_valid, inst_valid, pc);
        end
        respond(word_at(RESET_PC + 32'h4), 1'b0, '0, 1'b0, '0);
        // Redirect coinciding with the response also drops the word.
        issue_req(RESET_PC + 32'h100, 1'b0, '0);
        respond(word_at(RESET_PC + 32'h100), 1'b0, '0, 1'b1, RESET_PC + 32'h140);
        fetch_plain(RESET_PC + 32'h140);
    endtask

    task automatic test_redirect_hold();
        logic [31:0] a;
        a = RESET_PC + 32'h144;
        issue_req(a, 1'b0, '0);
        respond(word_at(a), 1'b1, a, 1'b0, '0);
        consume(1'b1, RESET_PC + 32'h200);
        fetch_plain(RESET_PC + 32'h200);
    endtask

    task automatic test_reset_mid_wait();
        issue_req(RESET_PC + 32'h204, 1'b0, '0);
        redirect_one_cycle(RESET_PC + 32'h300);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        resp_valid = 1'b1;
        resp_data  = word_at(RESET_PC + 32'h204);
        tick();
        resp_valid = 1'b0;
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== RESET_PC || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stale_after_reset: req=%b addr=%h inst=%b", req_valid, req_addr, inst_valid);
        end
        fetch_plain(RESET_PC);
    endtask

    task automatic test_wrap();
        redirect_one_cycle(32'hFFFF_FFFC);
        fetch_plain(32'hFFFF_FFFC);
        fetch_plain(32'h0000_0000);
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_hold_stall();
        test_redirect_req();
        test_redirect_wait();
        test_redirect_hold();
        test_reset_mid_wait();
        test_wrap();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d words never delivered", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
